// File: rtl/write_audio.sv
// write_audio: pops a left/right sample pair from two show-ahead FIFOs,
// dequantizes each by 2^BITS (truncating toward zero), saturates to
// CHAR_SIZE bits and emits four little-endian bytes (L-lo, L-hi, R-lo, R-hi)
// into a byte-wide output FIFO.
module write_audio #(
    parameter int DATA_SIZE = 32,
    parameter int CHAR_SIZE = 16,
    parameter int BYTE      = 8,
    parameter int BITS      = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        left_empty,
    input  logic                        right_empty,
    output logic                        in_rd_en,
    input  logic signed [DATA_SIZE-1:0] left_in,
    input  logic signed [DATA_SIZE-1:0] right_in,
    input  logic                        out_full,
    output logic                        out_wr_en,
    output logic [BYTE-1:0]             data_out
);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

    // Bias added to negative samples so the arithmetic shift rounds toward zero.
    localparam logic signed [DATA_SIZE-1:0] ROUND   = DATA_SIZE'((1 << BITS) - 1);
    localparam logic signed [DATA_SIZE-1:0] SAT_MAX = DATA_SIZE'((1 << (CHAR_SIZE - 1)) - 1);
    // Two's complement: ~MAX == -MAX-1 == most negative CHAR_SIZE value.
    localparam logic signed [DATA_SIZE-1:0] SAT_MIN = ~SAT_MAX;

    state_t               state;
    logic [CHAR_SIZE-1:0] l_word;
    logic [CHAR_SIZE-1:0] r_word;
    logic [CHAR_SIZE-1:0] l_deq;
    logic [CHAR_SIZE-1:0] r_deq;
    logic                 pair_ready;

    // Divide by 2^BITS toward zero, then clamp into the signed CHAR_SIZE range.
    function automatic logic [CHAR_SIZE-1:0] dequant(input logic signed [DATA_SIZE-1:0] x);
        logic signed [DATA_SIZE-1:0] q;
        if (x[DATA_SIZE-1])
            q = (x + ROUND) >>> BITS;
        else
            q = x >>> BITS;
        if (q > SAT_MAX)
            return SAT_MAX[CHAR_SIZE-1:0];
        else if (q < SAT_MIN)
            return SAT_MIN[CHAR_SIZE-1:0];
        else
            return q[CHAR_SIZE-1:0];
    endfunction

    // Dequantize the FIFO heads continuously; the result is captured on the pop.
    always_comb begin
        l_deq = dequant(left_in);
        r_deq = dequant(right_in);
    end

    // Pop/write strobes and byte mux; the pair is only popped when both sides
    // hold data and the frame slot is free (IDLE, or B3 while its byte goes out).
    always_comb begin
        pair_ready = !left_empty && !right_empty;
        out_wr_en  = (state != IDLE) && !out_full;
        in_rd_en   = pair_ready && ((state == IDLE) || ((state == B3) && !out_full));
        case (state)
            B1:      data_out = l_word[CHAR_SIZE-1:BYTE];
            B2:      data_out = r_word[BYTE-1:0];
            B3:      data_out = r_word[CHAR_SIZE-1:BYTE];
            default: data_out = l_word[BYTE-1:0];
        endcase
    end

    // Frame sequencer: latch a pair on pop, then step one byte per accepted write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            l_word <= '0;
            r_word <= '0;
        end else begin
            if (in_rd_en) begin
                l_word <= l_deq;
                r_word <= r_deq;
            end
            case (state)
                IDLE: if (in_rd_en) state <= B0;
                B0:   if (!out_full) state <= B1;
                B1:   if (!out_full) state <= B2;
                B2:   if (!out_full) state <= B3;
                B3:   if (!out_full) state <= in_rd_en ? B0 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_audio.sv
// tb_write_audio: drives show-ahead FIFO models and checks the byte stream
// against a plain-arithmetic dequantize/saturate reference.
module tb_write_audio;

    localparam int DS = 32;
    localparam int CS = 16;
    localparam int BY = 8;
    localparam int BT = 10;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 left_empty, right_empty, in_rd_en, out_wr_en;
    logic                 out_full = 1'b0;
    logic signed [DS-1:0] left_in, right_in;
    logic [BY-1:0]        data_out;

    write_audio #(.DATA_SIZE(DS), .CHAR_SIZE(CS), .BYTE(BY), .BITS(BT)) dut (
        .clock(clock), .reset(reset),
        .left_empty(left_empty), .right_empty(right_empty), .in_rd_en(in_rd_en),
        .left_in(left_in), .right_in(right_in),
        .out_full(out_full), .out_wr_en(out_wr_en), .data_out(data_out)
    );

    always #5 clock = ~clock;

    // Show-ahead input FIFO models
    int lmem [256];
    int rmem [256];
    int lhead = 0, rhead = 0, ltail = 0, rtail = 0, npaired = 0;

    assign left_empty  = (lhead >= ltail);
    assign right_empty = (rhead >= rtail);
    assign left_in     = lmem[lhead & 255];
    assign right_in    = rmem[rhead & 255];

    always @(posedge clock) begin
        if (in_rd_en) begin
            lhead <= lhead + 1;
            rhead <= rhead + 1;
        end
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         wr_cyc[$];
    int         rd_cyc[$];
    int         cyc = 0;
    bit         mon_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: integer division truncates toward zero, then clamp.
    function automatic logic [15:0] ref_dq(input int x);
        int q;
        q = x / 1024;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic push_left(input int x);
        lmem[ltail & 255] = x;
        ltail++;
    endtask

    task automatic push_right(input int x);
        rmem[rtail & 255] = x;
        rtail++;
    endtask

    // Expected bytes for every pair that now has both halves present.
    task automatic sync_exp();
        logic [15:0] lw, rw;
        while (npaired < ltail && npaired < rtail) begin
            lw = ref_dq(lmem[npaired & 255]);
            rw = ref_dq(rmem[npaired & 255]);
            exp_q.push_back(lw[7:0]);
            exp_q.push_back(lw[15:8]);
            exp_q.push_back(rw[7:0]);
            exp_q.push_back(rw[15:8]);
            npaired++;
        end
    endtask

    task automatic push_pair(input int l, input int r);
        push_left(l);
        push_right(r);
        sync_exp();
    endtask

    // Pair with hand-derived expected bytes.
    task automatic push_lit(input int l, input int r, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        push_left(l);
        push_right(r);
        npaired++;
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
    endtask

    function automatic int rnd_sample();
        case ($urandom_range(0, 3))
            0:       return int'($urandom);
            1:       return int'($urandom_range(0, 4095)) - 2048;
            2:       return int'($urandom_range(0, 67108863)) - 33554432;
            default: return (int'($urandom_range(0, 65535)) - 32768) * 1024;
        endcase
    endfunction

    task automatic drive();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            sample();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Output-side monitor: every write is matched against the expected stream.
    logic       prev_full = 1'b0, prev_rd = 1'b0;
    logic [7:0] prev_data = '0;
    initial forever begin
        @(negedge clock);
        cyc++;
        if (mon_en) begin
            if (in_rd_en) begin
                rd_cyc.push_back(cyc);
                chk("pop_empty", {left_empty, right_empty}, 0);
            end
            if (out_wr_en) begin
                wr_cyc.push_back(cyc);
                chk("wr_full", out_full, 0);
                chk("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("byte", data_out, exp_q.pop_front());
            end
            if (prev_full && out_full && !prev_rd) chk("stall_hold", data_out, prev_data);
        end
        prev_full = out_full;
        prev_rd   = in_rd_en;
        prev_data = data_out;
    end

    initial begin
        int bw, br, ok;

        // Reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        mon_en = 1;
        sample();
        chk("rst_rd", in_rd_en, 0);
        chk("rst_wr", out_wr_en, 0);
        chk("rst_data", data_out, 8'h00);

        // Single pair: latency, 4 consecutive writes, one pop, back to IDLE
        bw = wr_cyc.size(); br = rd_cyc.size();
        drive();
        push_lit(1024000, -1024000, 8'hE8, 8'h03, 8'h18, 8'hFC);
        wait_drain(20);
        repeat (3) sample();
        chk("sp_pops", rd_cyc.size() - br, 1);
        chk("sp_writes", wr_cyc.size() - bw, 4);
        if (rd_cyc.size() > br && wr_cyc.size() >= bw + 4) begin
            chk("sp_latency", wr_cyc[bw] - rd_cyc[br], 1);
            chk("sp_burst", wr_cyc[bw+3] - wr_cyc[bw], 3);
        end
        chk("sp_idle_wr", out_wr_en, 0);
        chk("sp_idle_data", data_out, 8'hE8);

        // Truncation toward zero and saturation
        drive();
        push_lit(-1, -1023, 8'h00, 8'h00, 8'h00, 8'h00);
        push_lit(-1025, 1025, 8'hFF, 8'hFF, 8'h01, 8'h00);
        push_lit(40000 * 1024, -40000 * 1024, 8'hFF, 8'h7F, 8'h00, 8'h80);
        wait_drain(40);

        // Backpressure in B1 for 3 cycles
        bw = wr_cyc.size();
        drive();
        push_lit(1024000, -1024000, 8'hE8, 8'h03, 8'h18, 8'hFC);
        ok = 0;
        while (wr_cyc.size() == bw && ok < 10) begin sample(); ok++; end
        drive();
        out_full = 1'b1;
        repeat (3) begin
            sample();
            chk("bp_data", data_out, 8'h03);
            chk("bp_wr", out_wr_en, 0);
        end
        drive();
        out_full = 1'b0;
        wait_drain(20);
        repeat (2) sample();
        chk("bp_writes", wr_cyc.size() - bw, 4);

        // Streaming: 8 preloaded pairs, no backpressure
        bw = wr_cyc.size(); br = rd_cyc.size();
        drive();
        for (int i = 0; i < 8; i++) push_pair(rnd_sample(), rnd_sample());
        wait_drain(100);
        repeat (3) sample();
        chk("st_writes", wr_cyc.size() - bw, 32);
        chk("st_pops", rd_cyc.size() - br, 8);
        if (wr_cyc.size() >= bw + 32) chk("st_contig", wr_cyc[bw+31] - wr_cyc[bw], 31);
        ok = 1;
        for (int i = 0; i + 1 < 8 && br + i + 1 < rd_cyc.size(); i++)
            if (rd_cyc[br+i+1] - rd_cyc[br+i] != 4) ok = 0;
        chk("st_pop_spacing", ok, 1);

        // Imbalance: left only must not pop
        bw = wr_cyc.size(); br = rd_cyc.size();
        drive();
        push_left(5000);
        repeat (6) sample();
        chk("imb_pops", rd_cyc.size() - br, 0);
        chk("imb_writes", wr_cyc.size() - bw, 0);
        drive();
        push_right(-7000);
        sync_exp();
        wait_drain(20);

        // Reset during B2: B2 byte goes out, then nothing more
        bw = wr_cyc.size();
        drive();
        push_left(1024000);
        push_right(-1024000);
        npaired++;
        exp_q.push_back(8'hE8);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h18);
        ok = 0;
        while (wr_cyc.size() < bw + 2 && ok < 10) begin sample(); ok++; end
        drive();
        reset = 1'b1;
        drive();
        reset = 1'b0;
        sample();
        chk("mr_data", data_out, 8'h00);
        chk("mr_wr", out_wr_en, 0);
        chk("mr_rd", in_rd_en, 0);
        repeat (5) sample();
        chk("mr_writes", wr_cyc.size() - bw, 3);

        // Random traffic with skewed pushes and random backpressure
        begin
            int nl = 0, nr = 0;
            for (int c = 0; c < 400; c++) begin
                drive();
                out_full = ($urandom_range(0, 3) == 0);
                if (nl < 24 && $urandom_range(0, 2) == 0) begin push_left(rnd_sample()); nl++; end
                if (nr < 24 && $urandom_range(0, 2) == 0) begin push_right(rnd_sample()); nr++; end
                sync_exp();
            end
            drive();
            while (nl < 24) begin push_left(rnd_sample()); nl++; end
            while (nr < 24) begin push_right(rnd_sample()); nr++; end
            sync_exp();
            out_full = 1'b0;
            wait_drain(200);
        end

        repeat (3) sample();
        chk("final_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/write_audio.md
# write_audio

Output-side byte serializer for the FM receiver datapath. It pops one left and one right audio sample from two show-ahead sample FIFOs and dequantizes each from fixed point by 2^BITS. Each result is saturated to CHAR_SIZE bits and written as little-endian bytes (L-lo, L-hi, R-lo, R-hi) into a byte-wide output FIFO. This byte stream is the exact inverse of the I/Q byte format used on the input side.

## Interface
- DATA_SIZE, 32: width of signed fixed-point input samples
- CHAR_SIZE, 16: width of each signed output sample (must equal 2*BYTE)
- BYTE, 8: output FIFO data width
- BITS, 10: fixed-point fraction bits removed by dequantization
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- left_empty  in  1  left sample FIFO empty
- right_empty  in  1  right sample FIFO empty
- in_rd_en  out  1  pops left and right FIFOs together (combinational)
- left_in  in  DATA_SIZE  signed left sample, valid while !left_empty (show-ahead)
- right_in  in  DATA_SIZE  signed right sample, valid while !right_empty
- out_full  in  1  output byte FIFO full
- out_wr_en  out  1  writes data_out this cycle (combinational)
- data_out  out  BYTE  byte being written

## Operation
- **State machine:** IDLE, B0, B1, B2, B3. Registers hold l_word and r_word (each CHAR_SIZE wide).
- **IDLE:**
  - If !left_empty && !right_empty: assert in_rd_en, latch the dequantized left_in and right_in into l_word and r_word, go to B0.
  - Otherwise stay in IDLE with in_rd_en=0.
- **B0..B3, byte selection:** B0 drives l_word[7:0], B1 drives l_word[15:8], B2 drives r_word[7:0], B3 drives r_word[15:8].
- **B0..B3, writes:**
  - If !out_full: out_wr_en=1 and advance to the next state.
  - If out_full: out_wr_en=0, hold state, and keep data_out stable.
- **B3 with a write:**
  - If both input FIFOs are non-empty in the same cycle: assert in_rd_en, latch the new pair, go to B0 (back-to-back, no IDLE bubble).
  - Otherwise go to IDLE.
- **Pop rules:**
  - in_rd_en is never asserted when either FIFO is empty.
  - in_rd_en is never asserted in B0..B2.
  - A single-sided non-empty FIFO is never popped alone.
- **Dequantize, per channel:**
  - Divide by 2^BITS with truncation toward zero: for a negative x, use (x + 2^BITS − 1) >>> BITS; otherwise use x >>> BITS.
  - Saturate the quotient to [−2^(CHAR_SIZE−1), 2^(CHAR_SIZE−1)−1].
  - All of this is done combinationally on the FIFO head, and the result is registered at the pop.
- **data_out when out_wr_en=0:** reflects the currently selected byte of the held words. In IDLE it is l_word[7:0].

## Timing
- **Reset:** on a clock edge with reset=1, state goes to IDLE and l_word=r_word=0. Resulting outputs: in_rd_en=0, out_wr_en=0, data_out=0x00.
- **Reset mid-frame:** any partially emitted frame is abandoned with no further bytes written. A pair already popped is lost.
- **Latency:** pop in cycle N, then the first byte is written in cycle N+1 if !out_full.
- **Throughput:** minimum 4 cycles per sample pair under continuous input and no backpressure. An isolated pair takes 5 cycles, IDLE to IDLE.
- **Backpressure:** out_full stalls the current byte indefinitely. No byte is skipped or duplicated, and the frame order is preserved.
- **Inputs during a stall:** input FIFO state is ignored in B0..B2, and in B3 while out_full=1.

## Test plan
- **Single pair:** left=1024000 (1000·2^10), right=−1024000 → exactly 4 writes 0xE8, 0x03, 0x18, 0xFC in consecutive cycles; one in_rd_en pulse; return to IDLE.
- **Truncation toward zero:**
  - left=−1, right=−1023 → bytes 00 00 00 00.
  - left=−1025, right=1025 → FF FF 01 00.
- **Saturation:** left=40000·2^10, right=−40000·2^10 → FF 7F 00 80.
- **Backpressure:** single pair; hold out_full=1 for 3 cycles while in B1 → data_out stays 0x03 throughout; out_wr_en low during the stall; the sequence completes with no duplicate or missing byte.
- **Streaming and imbalance:**
  - 8 pairs preloaded, out_full=0 → 32 bytes in 32 consecutive cycles; in_rd_en only in IDLE and B3.
  - Left FIFO non-empty with right empty → no pop and no writes.
- **Reset:** assert reset during B2 → the next cycle is IDLE with data_out=0x00; no further writes until a new pair is popped.
